// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing the physical-memory port between the I-cache and the D-cache.
// The winning request is latched on grant and held steady toward memory until pmem_resp.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0]        state_r;
  logic              last_grant_r;
  logic [ADDR_W-1:0] lat_addr_r;
  logic [LINE_W-1:0] lat_wdata_r;
  logic              lat_read_r;
  logic              lat_write_r;

  logic i_req_s;
  logic d_req_s;
  logic grant_i_s;
  logic grant_d_s;
  logic serving_s;

  // Request decode and round-robin grant: on a tie, the side that did not win last time wins
  always_comb begin
    i_req_s   = i_mem_read;
    d_req_s   = d_mem_read | d_mem_write;
    grant_i_s = i_req_s & (~d_req_s | last_grant_r);
    grant_d_s = d_req_s & (~i_req_s | ~last_grant_r);
  end

  // FSM and request latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b0;
      lat_addr_r   <= '0;
      lat_wdata_r  <= '0;
      lat_read_r   <= 1'b0;
      lat_write_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_i_s) begin
            state_r      <= SERVE_I;
            last_grant_r <= 1'b0;
            lat_addr_r   <= i_mem_address;
            lat_wdata_r  <= '0;
            lat_read_r   <= 1'b1;
            lat_write_r  <= 1'b0;
          end else if (grant_d_s) begin
            // A simultaneous read+write from the D-cache is resolved as a write-back
            state_r      <= SERVE_D;
            last_grant_r <= 1'b1;
            lat_addr_r   <= d_mem_address;
            lat_wdata_r  <= d_mem_wdata;
            lat_read_r   <= d_mem_read & ~d_mem_write;
            lat_write_r  <= d_mem_write;
          end else begin
            state_r <= IDLE;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Memory-side drive from the latches and response steering to the granted cache
  always_comb begin
    serving_s    = (state_r == SERVE_I) || (state_r == SERVE_D);
    pmem_read    = serving_s & lat_read_r;
    pmem_write   = serving_s & lat_write_r;
    pmem_address = lat_addr_r;
    pmem_wdata   = lat_wdata_r;
    if ((state_r == SERVE_I) && pmem_resp) begin
      i_mem_resp  = 1'b1;
      i_mem_rdata = pmem_rdata;
    end else begin
      i_mem_resp  = 1'b0;
      i_mem_rdata = '0;
    end
    if ((state_r == SERVE_D) && pmem_resp) begin
      d_mem_resp  = 1'b1;
      d_mem_rdata = pmem_rdata;
    end else begin
      d_mem_resp  = 1'b0;
      d_mem_rdata = '0;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: the bench plays both caches and the memory,
// driving inputs 1 time unit after the rising edge and sampling on the falling edge.
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] PAT_12 = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] PAT_FF = {LINE_W{1'b1}};
  localparam logic [LINE_W-1:0] PAT_D1 = {8{32'hD1D1_0001}};
  localparam logic [LINE_W-1:0] PAT_C3 = {8{32'hC3C3_0003}};

  logic              clk;
  logic              rst;
  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_address;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              i_mem_resp;
  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_address;
  logic [LINE_W-1:0] d_mem_wdata;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              d_mem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int checks = 0;
  int passed = 0;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] exp_rd;
    int cnt_read;
    int cnt_iresp;
    exp_rd = 5'b01110;
    cnt_read = 0;
    cnt_iresp = 0;
    rst = 1'b0;
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b0) $display("FAIL rst_pmem_read: got %b want 0", pmem_read); else passed++;
    checks++; if (pmem_write !== 1'b0) $display("FAIL rst_pmem_write: got %b want 0", pmem_write); else passed++;
    checks++; if ({i_mem_resp, d_mem_resp} !== 2'b00) $display("FAIL rst_resp: got %b want 00", {i_mem_resp, d_mem_resp}); else passed++;
    checks++; if ({i_mem_rdata, d_mem_rdata} !== {(2*LINE_W){1'b0}}) $display("FAIL rst_rdata: got nonzero want 0"); else passed++;
    #2 rst = 1'b1;
    tick();
    i_mem_read = 1'b1; i_mem_address = 32'h0000_1000;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin pmem_resp = 1'b1; pmem_rdata = PAT_A5; end
      else begin pmem_resp = 1'b0; pmem_rdata = '0; end
      if (c == 4) i_mem_read = 1'b0;
      @(negedge clk);
      checks++; if (pmem_read !== exp_rd[c]) $display("FAIL i_read_strobe c%0d: got %b want %b", c, pmem_read, exp_rd[c]); else passed++;
      if (pmem_read === 1'b1) cnt_read++;
      if (i_mem_resp === 1'b1) begin
        cnt_iresp++;
        checks++; if (i_mem_rdata !== PAT_A5) $display("FAIL i_rdata: got %h want %h", i_mem_rdata, PAT_A5); else passed++;
      end
      checks++; if (d_mem_resp !== 1'b0) $display("FAIL i_read_dresp c%0d: got %b want 0", c, d_mem_resp); else passed++;
      tick();
    end
    checks++; if (cnt_read != 3) $display("FAIL i_read_len: got %0d want 3", cnt_read); else passed++;
    checks++; if (cnt_iresp != 1) $display("FAIL i_resp_count: got %0d want 1", cnt_iresp); else passed++;
  endtask

  task automatic test_d_writeback();
    d_mem_write = 1'b1; d_mem_address = 32'h0000_2040; d_mem_wdata = PAT_12;
    tick();
    d_mem_wdata = PAT_FF;
    @(negedge clk);
    checks++; if ({pmem_write, pmem_read} !== 2'b10) $display("FAIL wb_strobes: got %b want 10", {pmem_write, pmem_read}); else passed++;
    checks++; if (pmem_address !== 32'h0000_2040) $display("FAIL wb_addr: got %h want 00002040", pmem_address); else passed++;
    checks++; if (pmem_wdata !== PAT_12) $display("FAIL wb_wdata: got %h want %h", pmem_wdata, PAT_12); else passed++;
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    checks++; if (pmem_wdata !== PAT_12) $display("FAIL wb_wdata_hold: got %h want %h", pmem_wdata, PAT_12); else passed++;
    checks++; if ({d_mem_resp, i_mem_resp} !== 2'b10) $display("FAIL wb_resp: got %b want 10", {d_mem_resp, i_mem_resp}); else passed++;
    tick();
    pmem_resp = 1'b0; d_mem_write = 1'b0;
    @(negedge clk);
    checks++; if ({d_mem_resp, pmem_write} !== 2'b00) $display("FAIL wb_idle: got %b want 00", {d_mem_resp, pmem_write}); else passed++;
    tick();
  endtask

  task automatic test_simultaneous();
    rst = 1'b0;
    #3 rst = 1'b1;
    tick();
    i_mem_read = 1'b1; i_mem_address = 32'h0000_0100;
    d_mem_read = 1'b1; d_mem_address = 32'h0000_0200;
    tick();
    pmem_resp = 1'b1; pmem_rdata = PAT_D1;
    @(negedge clk);
    checks++; if (pmem_address !== 32'h0000_0200) $display("FAIL sim_first_addr: got %h want 00000200", pmem_address); else passed++;
    checks++; if ({d_mem_resp, i_mem_resp} !== 2'b10) $display("FAIL sim_first_resp: got %b want 10", {d_mem_resp, i_mem_resp}); else passed++;
    checks++; if (d_mem_rdata !== PAT_D1) $display("FAIL sim_d_rdata: got %h want %h", d_mem_rdata, PAT_D1); else passed++;
    checks++; if (i_mem_rdata !== {LINE_W{1'b0}}) $display("FAIL sim_i_rdata_zero: got %h want 0", i_mem_rdata); else passed++;
    tick();
    d_mem_read = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b0) $display("FAIL sim_gap: got %b want 0", pmem_read); else passed++;
    tick();
    pmem_resp = 1'b1; pmem_rdata = PAT_C3;
    @(negedge clk);
    checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_0100}) $display("FAIL sim_second: got %b/%h want 1/00000100", pmem_read, pmem_address); else passed++;
    checks++; if (i_mem_rdata !== PAT_C3) $display("FAIL sim_i_rdata: got %h want %h", i_mem_rdata, PAT_C3); else passed++;
    tick();
    i_mem_read = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b0) $display("FAIL sim_end: got %b want 0", pmem_read); else passed++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_d;
    exp_d = 4'b0101;
    i_mem_read = 1'b1; i_mem_address = 32'h0000_0300;
    d_mem_read = 1'b1; d_mem_address = 32'h0000_0400;
    for (int k = 0; k < 4; k++) begin
      tick();
      pmem_resp = 1'b1;
      @(negedge clk);
      checks++;
      if (pmem_address !== (exp_d[k] ? 32'h0000_0400 : 32'h0000_0300))
        $display("FAIL rr_addr k%0d: got %h want %h", k, pmem_address, exp_d[k] ? 32'h0000_0400 : 32'h0000_0300);
      else passed++;
      checks++;
      if ({d_mem_resp, i_mem_resp} !== {exp_d[k], ~exp_d[k]})
        $display("FAIL rr_resp k%0d: got %b want %b", k, {d_mem_resp, i_mem_resp}, {exp_d[k], ~exp_d[k]});
      else passed++;
      tick();
      pmem_resp = 1'b0;
      if (k == 3) begin i_mem_read = 1'b0; d_mem_read = 1'b0; end
      @(negedge clk);
      checks++; if (pmem_read !== 1'b0) $display("FAIL rr_idle k%0d: got %b want 0", k, pmem_read); else passed++;
    end
    tick();
  endtask

  task automatic test_overlap();
    i_mem_read = 1'b1; i_mem_address = 32'h0000_0500;
    tick();
    d_mem_read = 1'b1; d_mem_address = 32'h0000_0600;
    @(negedge clk);
    checks++; if (pmem_address !== 32'h0000_0500) $display("FAIL ov_i_addr: got %h want 00000500", pmem_address); else passed++;
    tick();
    pmem_resp = 1'b1; pmem_rdata = PAT_A5;
    @(negedge clk);
    checks++; if ({i_mem_resp, d_mem_resp, pmem_address} !== {2'b10, 32'h0000_0500}) $display("FAIL ov_i_done: got %b/%h want 10/00000500", {i_mem_resp, d_mem_resp}, pmem_address); else passed++;
    tick();
    i_mem_read = 1'b0; pmem_resp = 1'b0;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b0) $display("FAIL ov_gap: got %b want 0", pmem_read); else passed++;
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    checks++; if ({pmem_read, pmem_address} !== {1'b1, 32'h0000_0600}) $display("FAIL ov_d_grant: got %b/%h want 1/00000600", pmem_read, pmem_address); else passed++;
    checks++; if (d_mem_resp !== 1'b1) $display("FAIL ov_d_resp: got %b want 1", d_mem_resp); else passed++;
    tick();
    d_mem_read = 1'b0; pmem_resp = 1'b0;
    tick();
  endtask

  task automatic test_spurious();
    pmem_resp = 1'b1; pmem_rdata = PAT_C3;
    @(negedge clk);
    checks++; if ({i_mem_resp, d_mem_resp} !== 2'b00) $display("FAIL spur_resp: got %b want 00", {i_mem_resp, d_mem_resp}); else passed++;
    checks++; if ({i_mem_rdata, d_mem_rdata} !== {(2*LINE_W){1'b0}}) $display("FAIL spur_rdata: got nonzero want 0"); else passed++;
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    checks++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL spur_state: got %b want 00", {pmem_read, pmem_write}); else passed++;
    tick();
  endtask

  task automatic test_rw_conflict();
    $display("note: driving d_mem_read and d_mem_write together (illegal input), expecting write precedence");
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 32'h0000_0800; d_mem_wdata = PAT_D1;
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    checks++; if ({pmem_write, pmem_read} !== 2'b10) $display("FAIL rw_precedence: got %b want 10", {pmem_write, pmem_read}); else passed++;
    tick();
    d_mem_read = 1'b0; d_mem_write = 1'b0; pmem_resp = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    i_mem_read = 1'b1; i_mem_address = 32'h0000_0700;
    tick();
    @(negedge clk);
    checks++; if (pmem_read !== 1'b1) $display("FAIL mid_serve1: got %b want 1", pmem_read); else passed++;
    tick();
    @(negedge clk);
    checks++; if (pmem_read !== 1'b1) $display("FAIL mid_serve2: got %b want 1", pmem_read); else passed++;
    #1 rst = 1'b0;
    #1;
    checks++; if (pmem_read !== 1'b0) $display("FAIL mid_async_drop: got %b want 0", pmem_read); else passed++;
    i_mem_read = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({pmem_read, i_mem_resp} !== 2'b00) $display("FAIL mid_after: got %b want 00", {pmem_read, i_mem_resp}); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_d_writeback();
    test_simultaneous();
    test_round_robin();
    test_overlap();
    test_spurious();
    test_rw_conflict();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory port (cacheline adaptor side) between the instruction cache and the data cache.
- Accepts 256-bit line read requests from the I-cache, and line read or write-back requests from the D-cache.
- Grants one request at a time, holds the granted address and data stable toward memory, and routes the response back to the winning requester.
- Sits between the two cache controllers and the cacheline adaptor.

Parameters:
- ADDR_W, 32, address width for both caches and memory.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_mem_read  in  1  I-cache line read request, held until i_mem_resp.
- i_mem_address  in  ADDR_W  I-cache line address (line-aligned).
- i_mem_rdata  out  LINE_W  line data returned to I-cache.
- i_mem_resp  out  1  one-cycle completion pulse to I-cache.
- d_mem_read  in  1  D-cache line read request.
- d_mem_write  in  1  D-cache line write-back request.
- d_mem_address  in  ADDR_W  D-cache line address.
- d_mem_wdata  in  LINE_W  D-cache write-back data.
- d_mem_rdata  out  LINE_W  line data returned to D-cache.
- d_mem_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_W  memory address.
- pmem_wdata  out  LINE_W  memory write data.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Registers:
  - state
  - last_grant (0 = I, 1 = D)
  - lat_addr
  - lat_wdata
  - lat_read
  - lat_write
- Reset (rst = 0, asynchronous):
  - state = IDLE, last_grant = 0, all latches = 0.
  - pmem_read, pmem_write, i_mem_resp and d_mem_resp are all 0 immediately.
  - rdata outputs are 0.
  - An in-flight memory transaction is abandoned; memory must also be reset.
- IDLE:
  - Only the I-cache requesting: go to SERVE_I.
  - Only the D-cache requesting (d_mem_read or d_mem_write): go to SERVE_D.
  - Both requesting: grant the requester not equal to last_grant (round-robin).
  - On grant, latch address, wdata (D only), read and write, and set last_grant.
  - Arbitration latency is 1 cycle: pmem strobes rise in the first SERVE cycle.
- SERVE_x:
  - pmem_read = lat_read, pmem_write = lat_write, pmem_address = lat_addr, pmem_wdata = lat_wdata.
  - All four are stable and unaffected by changes on the cache inputs.
  - Stay in SERVE_x until pmem_resp = 1.
  - In the pmem_resp cycle, x_mem_resp = 1 combinationally and x_mem_rdata = pmem_rdata.
  - The next state is IDLE.
- Strobes deassert in the IDLE cycle that follows the response. Minimum spacing between back-to-back grants is one IDLE cycle.
- In IDLE, pmem_read and pmem_write are 0, and both resp outputs are 0.
- The non-granted requester's resp stays 0 and its rdata is 0 throughout.
- The requester deasserts its request the cycle after its resp. A request still held in IDLE after resp is treated as a new request.
- d_mem_read and d_mem_write asserted together is illegal. The bench flags it; RTL gives write precedence (lat_read = 0, lat_write = 1).
- A pmem_resp arriving in IDLE is ignored: no resp is forwarded and the state is unchanged.
- Requests that arrive while in SERVE wait; the winner's request is held and the loser keeps asserting.

Test Plan:
- Reset mid-transaction:
  - Stimulus: reset released; I read to 0x0000_1000; memory responds after 3 cycles with data 0xA5..A5; then drive rst = 0 in the second SERVE cycle of a later transaction.
  - Required: pmem_read high for exactly the 3 cycles before and including resp; i_mem_resp pulses once with i_mem_rdata = 0xA5..A5; d_mem_resp stays 0.
  - Required on the later reset: pmem_read drops the same cycle rst goes low, without waiting for a clock edge.
- D write-back:
  - Stimulus: D write-back to 0x0000_2040 with wdata 0x1234..; change d_mem_wdata to 0xFFFF.. while in SERVE.
  - Required: pmem_write = 1, pmem_address = 0x0000_2040, pmem_wdata = the original 0x1234..; d_mem_resp pulses once.
- Simultaneous request after reset:
  - Stimulus: I read 0x100 and D read 0x200 raised in the same cycle after reset.
  - Required: D is served first (last_grant = I at reset), then I; there is exactly one IDLE cycle between the two pmem_read bursts.
- Round-robin fairness:
  - Stimulus: both caches request continuously for 4 transactions.
  - Required: grant order is D, I, D, I; no requester is starved.
- Overlapping late request:
  - Stimulus: D read is raised while SERVE_I is active.
  - Required: the I transaction completes unaffected; D is granted in the cycle after the following IDLE.
- Spurious response:
  - Stimulus: pmem_resp pulsed while in IDLE.
  - Required: no resp to either cache; the state remains IDLE.
